// File: rtl/ahblite_slave_mux.sv
// AHB-Lite data-phase response multiplexer for seven slave ports, with a built-in
// default slave that answers unmapped or disabled accesses with a two-cycle ERROR.
module ahblite_slave_mux #(
    parameter logic [6:0] PORT_EN   = 7'h7F,
    parameter int         ERR_CNT_W = 8
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 HREADY,
    input  logic [1:0]           HTRANS,
    input  logic                 P0_HSEL,
    input  logic                 P1_HSEL,
    input  logic                 P2_HSEL,
    input  logic                 P3_HSEL,
    input  logic                 P4_HSEL,
    input  logic                 P5_HSEL,
    input  logic                 P6_HSEL,
    input  logic                 P0_HREADYOUT,
    input  logic                 P1_HREADYOUT,
    input  logic                 P2_HREADYOUT,
    input  logic                 P3_HREADYOUT,
    input  logic                 P4_HREADYOUT,
    input  logic                 P5_HREADYOUT,
    input  logic                 P6_HREADYOUT,
    input  logic                 P0_HRESP,
    input  logic                 P1_HRESP,
    input  logic                 P2_HRESP,
    input  logic                 P3_HRESP,
    input  logic                 P4_HRESP,
    input  logic                 P5_HRESP,
    input  logic                 P6_HRESP,
    input  logic [31:0]          P0_HRDATA,
    input  logic [31:0]          P1_HRDATA,
    input  logic [31:0]          P2_HRDATA,
    input  logic [31:0]          P3_HRDATA,
    input  logic [31:0]          P4_HRDATA,
    input  logic [31:0]          P5_HRDATA,
    input  logic [31:0]          P6_HRDATA,
    output logic                 HREADYOUT,
    output logic                 HRESP,
    output logic [31:0]          HRDATA,
    output logic [ERR_CNT_W-1:0] ERR_COUNT
);

    localparam int NP = 7;

    typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} state_t;

    state_t                state_reg, state_next;
    logic [NP-1:0]         sel_reg, sel_next;
    logic [ERR_CNT_W-1:0]  err_cnt_reg, err_cnt_next;

    logic [NP-1:0]         hsel_vec, hready_vec, hresp_vec;
    logic [31:0]           hrdata_arr  [NP];
    logic [31:0]           data_masked [NP];
    logic [31:0]           data_or;
    logic [NP-1:0]         sel_vec, sel_onehot;
    logic                  unmapped, capture, err_enter;

    // Only HTRANS[1] distinguishes active transfers from IDLE/BUSY.
    logic htrans_unused;
    assign htrans_unused = HTRANS[0];

    assign hsel_vec   = {P6_HSEL, P5_HSEL, P4_HSEL, P3_HSEL, P2_HSEL, P1_HSEL, P0_HSEL};
    assign hready_vec = {P6_HREADYOUT, P5_HREADYOUT, P4_HREADYOUT, P3_HREADYOUT,
                         P2_HREADYOUT, P1_HREADYOUT, P0_HREADYOUT};
    assign hresp_vec  = {P6_HRESP, P5_HRESP, P4_HRESP, P3_HRESP, P2_HRESP, P1_HRESP, P0_HRESP};

    assign hrdata_arr[0] = P0_HRDATA;
    assign hrdata_arr[1] = P1_HRDATA;
    assign hrdata_arr[2] = P2_HRDATA;
    assign hrdata_arr[3] = P3_HRDATA;
    assign hrdata_arr[4] = P4_HRDATA;
    assign hrdata_arr[5] = P5_HRDATA;
    assign hrdata_arr[6] = P6_HRDATA;

    // Disabled ports look unmapped; overlapping selects resolve to the lowest index.
    assign sel_vec    = hsel_vec & PORT_EN;
    assign sel_onehot = sel_vec & (~sel_vec + NP'(1));
    assign unmapped   = (sel_vec == '0) && HTRANS[1];
    assign capture    = HREADY && (state_reg != ST_ERR1);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_reg   <= ST_IDLE;
            sel_reg     <= '0;
            err_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            sel_reg     <= sel_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_ERR2: begin
                if (HREADY) state_next = unmapped ? ST_ERR1 : ST_IDLE;
            end
            ST_ERR1: state_next = ST_ERR2;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_next = sel_reg;
        if (capture) sel_next = sel_onehot;
    end

    assign err_enter = (state_next == ST_ERR1) && (state_reg != ST_ERR1);

    always_comb begin
        err_cnt_next = err_cnt_reg;
        if (err_enter && (err_cnt_reg != '1)) err_cnt_next = err_cnt_reg + ERR_CNT_W'(1);
    end

    // sel_reg is one-hot or zero, so an OR of masked buses forms the read-data mux.
    for (genvar gi = 0; gi < NP; gi++) begin : g_mask
        assign data_masked[gi] = hrdata_arr[gi] & {32{sel_reg[gi]}};
    end

    always_comb begin
        data_or = '0;
        for (int i = 0; i < NP; i++) data_or = data_or | data_masked[i];
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = '0;
        case (state_reg)
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ST_ERR2: begin
                HREADYOUT = 1'b1;
                HRESP     = 1'b1;
            end
            default: begin
                if (sel_reg != '0) begin
                    HREADYOUT = |(sel_reg & hready_vec);
                    HRESP     = |(sel_reg & hresp_vec);
                    HRDATA    = data_or;
                end
            end
        endcase
    end

    assign ERR_COUNT = err_cnt_reg;

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Bench for ahblite_slave_mux: a default instance plus one with port 2 disabled and a
// 2-bit error counter, both checked against a transaction-level model of the data phase.
module tb_ahblite_slave_mux;

    logic        clk;
    logic        rst;
    logic [1:0]  htrans;
    logic [6:0]  hsel, s_ready, s_resp;
    logic [31:0] s_data [7];
    logic        hready_a, hready_b;
    logic        ready_a, resp_a, ready_b, resp_b;
    logic [31:0] data_a, data_b;
    logic [7:0]  cnt_a;
    logic [1:0]  cnt_b;

    int checks = 0;
    int errors = 0;

    // Model: what each instance's current data phase is (0 none, 1 slave, 2 error).
    int m_kind [2];
    int m_port [2];
    int m_cyc  [2];
    int m_cnt  [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ahblite_slave_mux dut_a (
        .HCLK(clk), .HRESET(rst), .HREADY(hready_a), .HTRANS(htrans),
        .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]), .P3_HSEL(hsel[3]),
        .P4_HSEL(hsel[4]), .P5_HSEL(hsel[5]), .P6_HSEL(hsel[6]),
        .P0_HREADYOUT(s_ready[0]), .P1_HREADYOUT(s_ready[1]), .P2_HREADYOUT(s_ready[2]),
        .P3_HREADYOUT(s_ready[3]), .P4_HREADYOUT(s_ready[4]), .P5_HREADYOUT(s_ready[5]),
        .P6_HREADYOUT(s_ready[6]),
        .P0_HRESP(s_resp[0]), .P1_HRESP(s_resp[1]), .P2_HRESP(s_resp[2]), .P3_HRESP(s_resp[3]),
        .P4_HRESP(s_resp[4]), .P5_HRESP(s_resp[5]), .P6_HRESP(s_resp[6]),
        .P0_HRDATA(s_data[0]), .P1_HRDATA(s_data[1]), .P2_HRDATA(s_data[2]),
        .P3_HRDATA(s_data[3]), .P4_HRDATA(s_data[4]), .P5_HRDATA(s_data[5]),
        .P6_HRDATA(s_data[6]),
        .HREADYOUT(ready_a), .HRESP(resp_a), .HRDATA(data_a), .ERR_COUNT(cnt_a)
    );

    ahblite_slave_mux #(.PORT_EN(7'h7B), .ERR_CNT_W(2)) dut_b (
        .HCLK(clk), .HRESET(rst), .HREADY(hready_b), .HTRANS(htrans),
        .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]), .P3_HSEL(hsel[3]),
        .P4_HSEL(hsel[4]), .P5_HSEL(hsel[5]), .P6_HSEL(hsel[6]),
        .P0_HREADYOUT(s_ready[0]), .P1_HREADYOUT(s_ready[1]), .P2_HREADYOUT(s_ready[2]),
        .P3_HREADYOUT(s_ready[3]), .P4_HREADYOUT(s_ready[4]), .P5_HREADYOUT(s_ready[5]),
        .P6_HREADYOUT(s_ready[6]),
        .P0_HRESP(s_resp[0]), .P1_HRESP(s_resp[1]), .P2_HRESP(s_resp[2]), .P3_HRESP(s_resp[3]),
        .P4_HRESP(s_resp[4]), .P5_HRESP(s_resp[5]), .P6_HRESP(s_resp[6]),
        .P0_HRDATA(s_data[0]), .P1_HRDATA(s_data[1]), .P2_HRDATA(s_data[2]),
        .P3_HRDATA(s_data[3]), .P4_HRDATA(s_data[4]), .P5_HRDATA(s_data[5]),
        .P6_HRDATA(s_data[6]),
        .HREADYOUT(ready_b), .HRESP(resp_b), .HRDATA(data_b), .ERR_COUNT(cnt_b)
    );

    function automatic logic [6:0] en_of(int d);
        return (d == 0) ? 7'h7F : 7'h7B;
    endfunction

    function automatic int max_of(int d);
        return (d == 0) ? 255 : 3;
    endfunction

    function automatic logic e_ready(int d);
        if (m_kind[d] == 1) return s_ready[m_port[d]];
        if (m_kind[d] == 2) return (m_cyc[d] == 2);
        return 1'b1;
    endfunction

    function automatic logic e_resp(int d);
        if (m_kind[d] == 1) return s_resp[m_port[d]];
        return (m_kind[d] == 2);
    endfunction

    function automatic logic [31:0] e_data(int d);
        if (m_kind[d] == 1) return s_data[m_port[d]];
        return 32'h0;
    endfunction

    function automatic void model_update(int d, logic hr);
        int found;
        logic [6:0] en;
        en = en_of(d);
        if (rst) begin
            m_kind[d] = 0;
            m_cyc[d]  = 0;
            m_cnt[d]  = 0;
        end else if (m_kind[d] == 2 && m_cyc[d] == 1) begin
            m_cyc[d] = 2;
        end else if (hr) begin
            found = -1;
            for (int i = 0; i < 7; i++)
                if (found < 0 && hsel[i] && en[i]) found = i;
            if (found >= 0) begin
                m_kind[d] = 1;
                m_port[d] = found;
            end else if (htrans[1]) begin
                m_kind[d] = 2;
                m_cyc[d]  = 1;
                if (m_cnt[d] < max_of(d)) m_cnt[d] = m_cnt[d] + 1;
            end else begin
                m_kind[d] = 0;
            end
        end
    endfunction

    // The system HREADY is the mux's own HREADYOUT, which the model predicts.
    task automatic step();
        logic hr0, hr1;
        hr0 = e_ready(0);
        hr1 = e_ready(1);
        hready_a = hr0;
        hready_b = hr1;
        @(posedge clk);
        model_update(0, hr0);
        model_update(1, hr1);
        @(negedge clk);
    endtask

    task automatic go_idle();
        hsel = '0;
        htrans = 2'b00;
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({ready_a, resp_a, data_a} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_held got=%b/%b/%h exp=1/0/0", ready_a, resp_a, data_a);
        end
        rst = 1'b0;
        step();
        checks++;
        if ({ready_a, resp_a, data_a, cnt_a} !== {1'b1, 1'b0, 32'h0, 8'd0}) begin
            errors++;
            $display("FAIL reset_release_a got=%b/%b/%h/%0d exp=1/0/0/0", ready_a, resp_a, data_a, cnt_a);
        end
        checks++;
        if ({ready_b, resp_b, data_b, cnt_b} !== {1'b1, 1'b0, 32'h0, 2'd0}) begin
            errors++;
            $display("FAIL reset_release_b got=%b/%b/%h/%0d exp=1/0/0/0", ready_b, resp_b, data_b, cnt_b);
        end
        $display("txn reset done");
    endtask

    task automatic test_mapped_read();
        s_data[1] = 32'hA5A5_0001;
        s_data[3] = 32'h3333_0003;
        hsel = 7'b000_0010;
        htrans = 2'b10;
        step();
        checks++;
        if ({data_a, resp_a, ready_a} !== {32'hA5A5_0001, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL read_p1 got=%h/%b/%b exp=a5a50001/0/1", data_a, resp_a, ready_a);
        end
        hsel = 7'b000_1000;
        step();
        s_data[1] = 32'h0000_FFFF;
        #1;
        checks++;
        if (data_a !== 32'h3333_0003) begin
            errors++;
            $display("FAIL read_p3 got=%h exp=33330003", data_a);
        end
        go_idle();
        checks++;
        if ({data_a, ready_a, resp_a} !== {32'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL read_idle got=%h/%b/%b exp=0/1/0", data_a, ready_a, resp_a);
        end
        $display("txn mapped reads P1 then P3 done");
    endtask

    task automatic test_wait_states();
        s_data[2] = 32'hC0DE_0002;
        s_data[3] = 32'hC0DE_0003;
        hsel = 7'b000_1000;
        htrans = 2'b10;
        step();
        s_ready[3] = 1'b0;
        hsel = 7'b000_0100;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if ({ready_a, data_a} !== {1'b0, 32'hC0DE_0003}) begin
                errors++;
                $display("FAIL wait_stall%0d got=%b/%h exp=0/c0de0003", k, ready_a, data_a);
            end
            if (k < 2) step();
        end
        s_ready[3] = 1'b1;
        #1;
        checks++;
        if (ready_a !== 1'b1) begin
            errors++;
            $display("FAIL wait_release got=%b exp=1", ready_a);
        end
        step();
        checks++;
        if (data_a !== 32'hC0DE_0002) begin
            errors++;
            $display("FAIL wait_next_p2 got=%h exp=c0de0002", data_a);
        end
        go_idle();
        $display("txn wait states P3 then P2 done");
    endtask

    task automatic test_unmapped();
        hsel = '0;
        htrans = 2'b10;
        step();
        checks++;
        if ({ready_a, resp_a, data_a} !== {1'b0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL unmapped_err1 got=%b/%b/%h exp=0/1/0", ready_a, resp_a, data_a);
        end
        htrans = 2'b00;
        step();
        checks++;
        if ({ready_a, resp_a} !== 2'b11) begin
            errors++;
            $display("FAIL unmapped_err2 got=%b/%b exp=1/1", ready_a, resp_a);
        end
        step();
        checks++;
        if ({ready_a, resp_a, cnt_a} !== {1'b1, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL unmapped_idle got=%b/%b/%0d exp=1/0/1", ready_a, resp_a, cnt_a);
        end
        step();
        checks++;
        if ({ready_a, resp_a, cnt_a} !== {1'b1, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL unmapped_idle_trans got=%b/%b/%0d exp=1/0/1", ready_a, resp_a, cnt_a);
        end
        $display("txn unmapped NONSEQ and IDLE done count=%0d", cnt_a);
    endtask

    task automatic test_back_to_back();
        hsel = '0;
        htrans = 2'b10;
        step();
        step();
        checks++;
        if ({ready_a, resp_a, cnt_a} !== {1'b1, 1'b1, 8'd2}) begin
            errors++;
            $display("FAIL b2b_err2 got=%b/%b/%0d exp=1/1/2", ready_a, resp_a, cnt_a);
        end
        step();
        checks++;
        if ({ready_a, resp_a, cnt_a} !== {1'b0, 1'b1, 8'd3}) begin
            errors++;
            $display("FAIL b2b_err1_again got=%b/%b/%0d exp=0/1/3", ready_a, resp_a, cnt_a);
        end
        go_idle();
        step();
        hsel = 7'b000_0100;
        htrans = 2'b10;
        step();
        checks++;
        if ({ready_b, resp_b} !== 2'b01) begin
            errors++;
            $display("FAIL disabled_port_b got=%b/%b exp=0/1", ready_b, resp_b);
        end
        checks++;
        if ({ready_a, resp_a, data_a} !== {1'b1, 1'b0, 32'hC0DE_0002}) begin
            errors++;
            $display("FAIL enabled_port_a got=%b/%b/%h exp=1/0/c0de0002", ready_a, resp_a, data_a);
        end
        go_idle();
        $display("txn back-to-back errors and disabled port done");
    endtask

    task automatic test_contention();
        s_data[0] = 32'hD000_0000;
        s_data[4] = 32'hD000_0004;
        hsel = 7'b001_0001;
        htrans = 2'b10;
        step();
        checks++;
        if (data_a !== 32'hD000_0000) begin
            errors++;
            $display("FAIL contention_a got=%h exp=d0000000", data_a);
        end
        checks++;
        if (data_b !== 32'hD000_0000) begin
            errors++;
            $display("FAIL contention_b got=%h exp=d0000000", data_b);
        end
        go_idle();
        $display("txn contention P0+P4 done");
    endtask

    task automatic test_saturation();
        int base_a;
        base_a = m_cnt[0];
        hsel = '0;
        htrans = 2'b10;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (cnt_b !== 2'(m_cnt[1])) begin
                errors++;
                $display("FAIL sat_step%0d got=%0d exp=%0d", k, cnt_b, m_cnt[1]);
            end
        end
        go_idle();
        checks++;
        if (cnt_b !== 2'd3) begin
            errors++;
            $display("FAIL sat_hold got=%0d exp=3", cnt_b);
        end
        checks++;
        if (cnt_a !== 8'(base_a + 5)) begin
            errors++;
            $display("FAIL sat_count_a got=%0d exp=%0d", cnt_a, base_a + 5);
        end
        $display("txn saturation count_b=%0d count_a=%0d", cnt_b, cnt_a);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            case ($urandom_range(0, 3))
                0: hsel = '0;
                1: hsel = 7'(1 << $urandom_range(0, 6));
                default: hsel = 7'($urandom);
            endcase
            htrans = 2'($urandom);
            for (int i = 0; i < 7; i++) begin
                s_ready[i] = ($urandom_range(0, 3) != 0);
                s_resp[i]  = ($urandom_range(0, 7) == 0);
                s_data[i]  = $urandom;
            end
            step();
            checks++;
            if ({ready_a, resp_a, data_a, cnt_a} !== {e_ready(0), e_resp(0), e_data(0), 8'(m_cnt[0])}) begin
                errors++;
                $display("FAIL rand_a%0d got=%b/%b/%h/%0d exp=%b/%b/%h/%0d", n, ready_a, resp_a, data_a,
                         cnt_a, e_ready(0), e_resp(0), e_data(0), m_cnt[0]);
            end
            checks++;
            if ({ready_b, resp_b, data_b, cnt_b} !== {e_ready(1), e_resp(1), e_data(1), 2'(m_cnt[1])}) begin
                errors++;
                $display("FAIL rand_b%0d got=%b/%b/%h/%0d exp=%b/%b/%h/%0d", n, ready_b, resp_b, data_b,
                         cnt_b, e_ready(1), e_resp(1), e_data(1), m_cnt[1]);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            s_ready[i] = 1'b1;
            s_resp[i]  = 1'b0;
        end
        go_idle();
        $display("txn random 400 cycles done");
    endtask

    task automatic test_reset_in_err1();
        rst = 1'b0;
        go_idle();
        hsel = '0;
        htrans = 2'b10;
        step();
        checks++;
        if (ready_a !== 1'b0) begin
            errors++;
            $display("FAIL rst_err1_entry got=%b exp=0", ready_a);
        end
        rst = 1'b1;
        htrans = 2'b00;
        step();
        checks++;
        if ({ready_a, resp_a, cnt_a, ready_b, resp_b, cnt_b} !== {1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL rst_in_err1 got=%b/%b/%0d %b/%b/%0d exp=1/0/0 1/0/0",
                     ready_a, resp_a, cnt_a, ready_b, resp_b, cnt_b);
        end
        rst = 1'b0;
        step();
        $display("txn reset during ERR1 done");
    endtask

    initial begin
        rst = 1'b1;
        htrans = 2'b00;
        hsel = '0;
        s_ready = '1;
        s_resp = '0;
        for (int i = 0; i < 7; i++) s_data[i] = 32'h0;
        hready_a = 1'b1;
        hready_b = 1'b1;
        for (int d = 0; d < 2; d++) begin
            m_kind[d] = 0;
            m_port[d] = 0;
            m_cyc[d]  = 0;
            m_cnt[d]  = 0;
        end
        @(negedge clk);
        test_reset();
        test_mapped_read();
        test_wait_states();
        test_unmapped();
        test_back_to_back();
        test_contention();
        test_saturation();
        test_random();
        test_reset_in_err1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
